// File: rtl/carfield_mbox_unit.sv
`default_nettype none
// ============================================================================
// Module   : carfield_mbox_unit
// Brief    : Two-sided mailbox with one 32-bit FIFO per direction and
//            per-side IRQ_EN / IRQ_STAT registers. Define
//            CARFIELD_MBOX_OVF_IRQ_EN to enable the tx_overflow sticky bit.
// Revision : 1.0 - initial release
// ============================================================================
module carfield_mbox_unit #(
    parameter int Depth = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        reg_a_valid_i,
    input  logic        reg_a_write_i,
    input  logic [11:0] reg_a_addr_i,
    input  logic [31:0] reg_a_wdata_i,
    input  logic [3:0]  reg_a_wstrb_i,
    output logic        reg_a_ready_o,
    output logic [31:0] reg_a_rdata_o,
    output logic        reg_a_error_o,

    input  logic        reg_b_valid_i,
    input  logic        reg_b_write_i,
    input  logic [11:0] reg_b_addr_i,
    input  logic [31:0] reg_b_wdata_i,
    input  logic [3:0]  reg_b_wstrb_i,
    output logic        reg_b_ready_o,
    output logic [31:0] reg_b_rdata_o,
    output logic        reg_b_error_o,

    output logic        irq_a_o,
    output logic        irq_b_o
);

    localparam int c_PtrW = $clog2(Depth);
    localparam int c_CntW = c_PtrW + 1;
    localparam logic [c_CntW-1:0] c_CntFull = c_CntW'(Depth);

`ifdef CARFIELD_MBOX_OVF_IRQ_EN
    localparam logic [1:0] c_IrqMask = 2'b11;
`else
    localparam logic [1:0] c_IrqMask = 2'b01;
`endif

    localparam logic [11:0] c_OffTx   = 12'h000;
    localparam logic [11:0] c_OffRx   = 12'h004;
    localparam logic [11:0] c_OffStat = 12'h008;
    localparam logic [11:0] c_OffEn   = 12'h00C;
    localparam logic [11:0] c_OffIrq  = 12'h010;

    // Side 0 = A (host), side 1 = B (security island); FIFO n is written by side n.
    logic [1:0]  w_valid;
    logic [1:0]  w_write;
    logic [11:0] w_addr  [2];
    logic [31:0] w_wdata [2];
    logic [3:0]  w_wstrb [2];

    assign w_valid    = {reg_b_valid_i, reg_a_valid_i};
    assign w_write    = {reg_b_write_i, reg_a_write_i};
    assign w_addr[0]  = reg_a_addr_i;
    assign w_addr[1]  = reg_b_addr_i;
    assign w_wdata[0] = reg_a_wdata_i;
    assign w_wdata[1] = reg_b_wdata_i;
    assign w_wstrb[0] = reg_a_wstrb_i;
    assign w_wstrb[1] = reg_b_wstrb_i;

    logic [1:0]        w_sidePush;
    logic [1:0]        w_sidePop;
    logic [1:0]        w_sideError;
    logic [1:0]        w_sideIrq;
    logic [31:0]       w_sideRdata [2];
    logic [c_CntW-1:0] w_count     [2];
    logic [31:0]       w_head      [2];
    logic [1:0]        w_empty;
    logic [1:0]        w_full;

    genvar f, s;
    generate
        for (f = 0; f < 2; f++) begin : g_fifo
            localparam bit c_Rd = (f == 0);

            logic [31:0]       r_mem [Depth];
            logic [c_PtrW-1:0] r_wrPtr;
            logic [c_PtrW-1:0] r_rdPtr;
            logic [c_CntW-1:0] r_count;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_wrPtr <= '0;
                    r_rdPtr <= '0;
                    r_count <= '0;
                end else begin
                    if (w_sidePush[f]) r_wrPtr <= r_wrPtr + 1'b1;
                    if (w_sidePop[c_Rd]) r_rdPtr <= r_rdPtr + 1'b1;
                    if (w_sidePush[f] && !w_sidePop[c_Rd]) begin
                        r_count <= r_count + 1'b1;
                    end else if (!w_sidePush[f] && w_sidePop[c_Rd]) begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end

            // Storage is deliberately unreset; the count alone defines validity.
            always_ff @(posedge clk_i) begin
                if (w_sidePush[f]) r_mem[r_wrPtr] <= w_wdata[f];
            end

            assign w_count[f] = r_count;
            assign w_empty[f] = (r_count == '0);
            assign w_full[f]  = (r_count == c_CntFull);
            assign w_head[f]  = r_mem[r_rdPtr];
        end

        for (s = 0; s < 2; s++) begin : g_side
            localparam bit c_Rx = (s == 0);

            logic [31:0] w_rdata;
            logic [31:0] w_status;
            logic        w_error;
            logic        w_push;
            logic        w_pop;
            logic        w_enWr;
            logic        w_ovf;
            logic [1:0]  w_w1c;
            logic [1:0]  w_set;
            logic [1:0]  r_irqEn;
            logic [1:0]  r_irqStat;
            logic        r_irq;

            assign w_status = {16'h0000, {(8 - c_CntW){1'b0}}, w_count[c_Rx], 4'h0,
                               w_full[s], w_empty[s], w_full[c_Rx], w_empty[c_Rx]};

            always_comb begin
                w_rdata = 32'h0;
                w_error = 1'b0;
                w_push  = 1'b0;
                w_pop   = 1'b0;
                w_enWr  = 1'b0;
                w_ovf   = 1'b0;
                w_w1c   = 2'b00;
                if (w_valid[s]) begin
                    case (w_addr[s])
                        c_OffTx: begin
                            if (!w_write[s] || (w_wstrb[s] != 4'hF)) begin
                                w_error = 1'b1;
                            end else if (w_full[s]) begin
                                w_error = 1'b1;
                                w_ovf   = 1'b1;
                            end else begin
                                w_push = 1'b1;
                            end
                        end
                        c_OffRx: begin
                            if (w_write[s] || w_empty[c_Rx]) begin
                                w_error = 1'b1;
                            end else begin
                                w_pop   = 1'b1;
                                w_rdata = w_head[c_Rx];
                            end
                        end
                        c_OffStat: begin
                            if (w_write[s]) w_error = 1'b1;
                            else            w_rdata = w_status;
                        end
                        c_OffEn: begin
                            if (w_write[s]) w_enWr  = 1'b1;
                            else            w_rdata = {30'h0, r_irqEn};
                        end
                        c_OffIrq: begin
                            if (w_write[s]) w_w1c   = w_wdata[s][1:0];
                            else            w_rdata = {30'h0, r_irqStat};
                        end
                        default: w_error = 1'b1;
                    endcase
                end
            end

            // rx_pending follows the peer's accepted push into our RX FIFO.
            assign w_set = {w_ovf, w_sidePush[c_Rx]};

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_irqEn   <= 2'b00;
                    r_irqStat <= 2'b00;
                    r_irq     <= 1'b0;
                end else begin
                    if (w_enWr) r_irqEn <= w_wdata[s][1:0] & c_IrqMask;
                    r_irqStat <= ((r_irqStat & ~w_w1c) | w_set) & c_IrqMask;
                    r_irq     <= |(r_irqEn & r_irqStat);
                end
            end

            assign w_sidePush[s]  = w_push;
            assign w_sidePop[s]   = w_pop;
            assign w_sideError[s] = w_error;
            assign w_sideRdata[s] = w_rdata;
            assign w_sideIrq[s]   = r_irq;
        end
    endgenerate

    assign reg_a_ready_o = reg_a_valid_i;
    assign reg_b_ready_o = reg_b_valid_i;
    assign reg_a_rdata_o = w_sideRdata[0];
    assign reg_b_rdata_o = w_sideRdata[1];
    assign reg_a_error_o = w_sideError[0];
    assign reg_b_error_o = w_sideError[1];
    assign irq_a_o       = w_sideIrq[0];
    assign irq_b_o       = w_sideIrq[1];

endmodule
`default_nettype wire

// File: tb/tb_carfield_mbox_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_carfield_mbox_unit
// Brief    : Vector table, directed corner sequences and randomized traffic
//            checked against a queue-based mailbox model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carfield_mbox_unit;

    localparam int c_Depth = 4;
`ifdef CARFIELD_MBOX_OVF_IRQ_EN
    localparam logic [1:0] c_IrqMask = 2'b11;
`else
    localparam logic [1:0] c_IrqMask = 2'b01;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_a_valid_i, reg_a_write_i, reg_b_valid_i, reg_b_write_i;
    logic [11:0] reg_a_addr_i, reg_b_addr_i;
    logic [31:0] reg_a_wdata_i, reg_b_wdata_i;
    logic [3:0]  reg_a_wstrb_i, reg_b_wstrb_i;
    logic        reg_a_ready_o, reg_b_ready_o, reg_a_error_o, reg_b_error_o;
    logic [31:0] reg_a_rdata_o, reg_b_rdata_o;
    logic        irq_a_o, irq_b_o;

    always #5 clk = ~clk;

    carfield_mbox_unit #(.Depth(c_Depth)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_a_valid_i(reg_a_valid_i), .reg_a_write_i(reg_a_write_i),
        .reg_a_addr_i(reg_a_addr_i), .reg_a_wdata_i(reg_a_wdata_i),
        .reg_a_wstrb_i(reg_a_wstrb_i), .reg_a_ready_o(reg_a_ready_o),
        .reg_a_rdata_o(reg_a_rdata_o), .reg_a_error_o(reg_a_error_o),
        .reg_b_valid_i(reg_b_valid_i), .reg_b_write_i(reg_b_write_i),
        .reg_b_addr_i(reg_b_addr_i), .reg_b_wdata_i(reg_b_wdata_i),
        .reg_b_wstrb_i(reg_b_wstrb_i), .reg_b_ready_o(reg_b_ready_o),
        .reg_b_rdata_o(reg_b_rdata_o), .reg_b_error_o(reg_b_error_o),
        .irq_a_o(irq_a_o), .irq_b_o(irq_b_o)
    );

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        side;
        req_t        req;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    // Model: mq[n] holds the words side n has sent and the peer has not yet read.
    logic [31:0] mq [2][$];
    logic [1:0]  mEn   [2];
    logic [1:0]  mStat [2];
    logic        mIrq  [2];

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic req_t mkreq(input bit v, input bit w, input logic [11:0] a,
                                   input logic [31:0] d, input logic [3:0] st);
        req_t r;
        r.valid = v; r.write = w; r.addr = a; r.wdata = d; r.wstrb = st;
        return r;
    endfunction

    function automatic logic [31:0] statusWord(input int s);
        int tx = mq[s].size();
        int rx = mq[1-s].size();
        return {16'h0, 8'(rx), 4'h0, (tx == c_Depth), (tx == 0), (rx == c_Depth), (rx == 0)};
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 2; s++) begin
            mq[s].delete();
            mEn[s] = 2'b00; mStat[s] = 2'b00; mIrq[s] = 1'b0;
        end
    endtask

    task automatic cycle(input req_t ra, input req_t rb,
                         output logic [31:0] rdA, output logic [31:0] rdB,
                         output logic erA, output logic erB);
        req_t        r [2];
        logic [31:0] eRd [2];
        logic [31:0] aRd [2];
        logic        eEr [2], aEr [2], aRdy [2];
        logic        doPush [2], doPop [2], ovf [2], enWr [2];
        logic [1:0]  w1c [2];
        r[0] = ra; r[1] = rb;
        @(negedge clk);
        reg_a_valid_i = ra.valid; reg_a_write_i = ra.write; reg_a_addr_i = ra.addr;
        reg_a_wdata_i = ra.wdata; reg_a_wstrb_i = ra.wstrb;
        reg_b_valid_i = rb.valid; reg_b_write_i = rb.write; reg_b_addr_i = rb.addr;
        reg_b_wdata_i = rb.wdata; reg_b_wstrb_i = rb.wstrb;
        #1;
        aRd[0] = reg_a_rdata_o; aEr[0] = reg_a_error_o; aRdy[0] = reg_a_ready_o;
        aRd[1] = reg_b_rdata_o; aEr[1] = reg_b_error_o; aRdy[1] = reg_b_ready_o;
        for (int s = 0; s < 2; s++) begin
            int rx;
            rx = 1 - s;
            eRd[s] = 32'h0; eEr[s] = 1'b0; doPush[s] = 1'b0; doPop[s] = 1'b0;
            ovf[s] = 1'b0; enWr[s] = 1'b0; w1c[s] = 2'b00;
            if (r[s].valid) begin
                case (r[s].addr)
                    12'h000: if (!r[s].write || r[s].wstrb != 4'hF) eEr[s] = 1'b1;
                             else if (mq[s].size() == c_Depth) begin eEr[s] = 1'b1; ovf[s] = 1'b1; end
                             else doPush[s] = 1'b1;
                    12'h004: if (r[s].write || mq[rx].size() == 0) eEr[s] = 1'b1;
                             else begin doPop[s] = 1'b1; eRd[s] = mq[rx][0]; end
                    12'h008: if (r[s].write) eEr[s] = 1'b1; else eRd[s] = statusWord(s);
                    12'h00C: if (r[s].write) enWr[s] = 1'b1; else eRd[s] = {30'h0, mEn[s]};
                    12'h010: if (r[s].write) w1c[s] = r[s].wdata[1:0]; else eRd[s] = {30'h0, mStat[s]};
                    default: eEr[s] = 1'b1;
                endcase
            end
            check($sformatf("ready%0d", s), {31'h0, aRdy[s]}, {31'h0, r[s].valid});
            if (r[s].valid) begin
                check($sformatf("rdata%0d@%03h", s, r[s].addr), aRd[s], eRd[s]);
                check($sformatf("error%0d@%03h", s, r[s].addr), {31'h0, aEr[s]}, {31'h0, eEr[s]});
            end
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) if (doPop[s]) void'(mq[1-s].pop_front());
        for (int s = 0; s < 2; s++) if (doPush[s]) mq[s].push_back(r[s].wdata);
        for (int s = 0; s < 2; s++) begin
            mIrq[s]  = |(mEn[s] & mStat[s]);
            mStat[s] = ((mStat[s] & ~w1c[s]) | {ovf[s], doPush[1-s]}) & c_IrqMask;
            if (enWr[s]) mEn[s] = r[s].wdata[1:0] & c_IrqMask;
        end
        check("irq_a", {31'h0, irq_a_o}, {31'h0, mIrq[0]});
        check("irq_b", {31'h0, irq_b_o}, {31'h0, mIrq[1]});
        reg_a_valid_i = 1'b0; reg_b_valid_i = 1'b0;
        rdA = aRd[0]; rdB = aRd[1]; erA = aEr[0]; erB = aEr[1];
    endtask

    task automatic acc(input bit side, input req_t r, output logic [31:0] rd, output logic er);
        logic [31:0] d0, d1;
        logic        e0, e1;
        if (side) cycle(mkreq(0, 0, 0, 0, 0), r, d0, d1, e0, e1);
        else      cycle(r, mkreq(0, 0, 0, 0, 0), d0, d1, e0, e1);
        rd = side ? d1 : d0;
        er = side ? e1 : e0;
    endtask

    task automatic idle(input int n);
        logic [31:0] d0, d1;
        logic        e0, e1;
        repeat (n) cycle(mkreq(0, 0, 0, 0, 0), mkreq(0, 0, 0, 0, 0), d0, d1, e0, e1);
    endtask

    function automatic req_t randReq();
        req_t r;
        int   k;
        logic [11:0] odd [3];
        odd[0] = 12'h014; odd[1] = 12'hFFC; odd[2] = 12'h002;
        k = $urandom_range(0, 9);
        r.valid = ($urandom_range(0, 9) < 7);
        r.wdata = $urandom;
        r.wstrb = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
        r.write = $urandom_range(0, 1);
        if (k < 3)       begin r.addr = 12'h000; r.write = ($urandom_range(0, 9) != 0); end
        else if (k < 6)  begin r.addr = 12'h004; r.write = ($urandom_range(0, 9) == 0); end
        else if (k == 6) r.addr = 12'h008;
        else if (k == 7) r.addr = 12'h00C;
        else if (k == 8) r.addr = 12'h010;
        else             r.addr = odd[$urandom_range(0, 2)];
        return r;
    endfunction

    vec_t        vecs [22];
    logic [31:0] rd, rdA, rdB;
    logic        er, erA, erB;

    initial begin
        reg_a_valid_i = 0; reg_a_write_i = 0; reg_a_addr_i = 0; reg_a_wdata_i = 0; reg_a_wstrb_i = 0;
        reg_b_valid_i = 0; reg_b_write_i = 0; reg_b_addr_i = 0; reg_b_wdata_i = 0; reg_b_wstrb_i = 0;
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        check("irq_a_in_reset", {31'h0, irq_a_o}, 32'h0);
        check("irq_b_in_reset", {31'h0, irq_b_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{1'b1, mkreq(1, 0, 12'h008, 0, 4'hF), 32'h5, 1'b0};
        vecs[1]  = '{1'b0, mkreq(1, 0, 12'h008, 0, 4'hF), 32'h5, 1'b0};
        vecs[2]  = '{1'b0, mkreq(1, 1, 12'h000, 32'hDEADBEEF, 4'hF), 32'h0, 1'b0};
        vecs[3]  = '{1'b1, mkreq(1, 0, 12'h008, 0, 4'hF), 32'h104, 1'b0};
        vecs[4]  = '{1'b0, mkreq(1, 0, 12'h008, 0, 4'hF), 32'h1, 1'b0};
        vecs[5]  = '{1'b1, mkreq(1, 0, 12'h004, 0, 4'hF), 32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b1, mkreq(1, 0, 12'h008, 0, 4'hF), 32'h5, 1'b0};
        vecs[7]  = '{1'b0, mkreq(1, 0, 12'h004, 0, 4'hF), 32'h0, 1'b1};
        vecs[8]  = '{1'b0, mkreq(1, 0, 12'h008, 0, 4'hF), 32'h5, 1'b0};
        vecs[9]  = '{1'b0, mkreq(1, 0, 12'h000, 0, 4'hF), 32'h0, 1'b1};
        vecs[10] = '{1'b1, mkreq(1, 1, 12'h004, 32'h1, 4'hF), 32'h0, 1'b1};
        vecs[11] = '{1'b0, mkreq(1, 1, 12'h008, 32'h1, 4'hF), 32'h0, 1'b1};
        vecs[12] = '{1'b0, mkreq(1, 0, 12'h020, 0, 4'hF), 32'h0, 1'b1};
        vecs[13] = '{1'b0, mkreq(1, 1, 12'h000, 32'h12345678, 4'h7), 32'h0, 1'b1};
        vecs[14] = '{1'b1, mkreq(1, 0, 12'h008, 0, 4'hF), 32'h5, 1'b0};
        vecs[15] = '{1'b1, mkreq(1, 0, 12'h010, 0, 4'hF), 32'h1, 1'b0};
        vecs[16] = '{1'b1, mkreq(1, 1, 12'h010, 32'h1, 4'hF), 32'h0, 1'b0};
        vecs[17] = '{1'b1, mkreq(1, 0, 12'h010, 0, 4'hF), 32'h0, 1'b0};
        vecs[18] = '{1'b1, mkreq(1, 1, 12'h00C, 32'h3, 4'hF), 32'h0, 1'b0};
        vecs[19] = '{1'b1, mkreq(1, 0, 12'h00C, 0, 4'hF), {30'h0, c_IrqMask}, 1'b0};
        vecs[20] = '{1'b1, mkreq(1, 1, 12'h00C, 32'h0, 4'hF), 32'h0, 1'b0};
        vecs[21] = '{1'b0, mkreq(1, 0, 12'h010, 0, 4'hF), 32'h0, 1'b0};

        for (int i = 0; i < 22; i++) begin
            acc(vecs[i].side, vecs[i].req, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
            check($sformatf("vec%0d_error", i), {31'h0, er}, {31'h0, vecs[i].expErr});
        end

        // A request with valid low must not push.
        acc(0, mkreq(0, 1, 12'h000, 32'hBAD0BAD0, 4'hF), rd, er);
        acc(1, mkreq(1, 0, 12'h008, 0, 4'hF), rd, er);
        check("novalid_status", rd, 32'h5);

        // rx_pending interrupt: raise one cycle after the push edge, drop after W1C.
        acc(1, mkreq(1, 1, 12'h00C, 32'h1, 4'hF), rd, er);
        acc(0, mkreq(1, 1, 12'h000, 32'h11112222, 4'hF), rd, er);
        check("irqb_at_push_edge", {31'h0, irq_b_o}, 32'h0);
        idle(1);
        check("irqb_after_push", {31'h0, irq_b_o}, 32'h1);
        acc(1, mkreq(1, 0, 12'h004, 0, 4'hF), rd, er);
        check("irqb_pop_data", rd, 32'h11112222);
        acc(1, mkreq(1, 1, 12'h010, 32'h1, 4'hF), rd, er);
        idle(1);
        check("irqb_after_w1c", {31'h0, irq_b_o}, 32'h0);
        acc(1, mkreq(1, 1, 12'h00C, 32'h0, 4'hF), rd, er);

        // Overflow on the fifth push, then in-order drain.
        for (int i = 0; i < 5; i++) begin
            acc(0, mkreq(1, 1, 12'h000, 32'hA000_0000 + i, 4'hF), rd, er);
            check($sformatf("ovf_push%0d_err", i), {31'h0, er}, (i == 4) ? 32'h1 : 32'h0);
        end
        acc(0, mkreq(1, 0, 12'h010, 0, 4'hF), rd, er);
        check("ovf_irqstat_a", rd, {30'h0, c_IrqMask & 2'b10});
        for (int i = 0; i < 4; i++) begin
            acc(1, mkreq(1, 0, 12'h004, 0, 4'hF), rd, er);
            check($sformatf("ovf_drain%0d", i), rd, 32'hA000_0000 + i);
        end
        acc(0, mkreq(1, 1, 12'h010, 32'h3, 4'hF), rd, er);
        acc(1, mkreq(1, 1, 12'h010, 32'h3, 4'hF), rd, er);

        // Full FIFO: concurrent push (rejected on pre-cycle count) and pop.
        for (int i = 0; i < 4; i++) acc(0, mkreq(1, 1, 12'h000, 32'hC000_0000 + i, 4'hF), rd, er);
        cycle(mkreq(1, 1, 12'h000, 32'hCCCC_CCCC, 4'hF), mkreq(1, 0, 12'h004, 0, 4'hF), rdA, rdB, erA, erB);
        check("full_pushpop_erra", {31'h0, erA}, 32'h1);
        check("full_pushpop_rdb", rdB, 32'hC000_0000);
        check("full_pushpop_errb", {31'h0, erB}, 32'h0);
        acc(1, mkreq(1, 0, 12'h008, 0, 4'hF), rd, er);
        check("full_pushpop_status", rd, 32'h0000_0304);
        for (int i = 1; i < 4; i++) begin
            acc(1, mkreq(1, 0, 12'h004, 0, 4'hF), rd, er);
            check($sformatf("full_drain%0d", i), rd, 32'hC000_0000 + i);
        end

        // Reset with two words queued and irq_b pending.
        acc(1, mkreq(1, 1, 12'h00C, 32'h1, 4'hF), rd, er);
        acc(0, mkreq(1, 1, 12'h000, 32'h5555_0001, 4'hF), rd, er);
        acc(0, mkreq(1, 1, 12'h000, 32'h5555_0002, 4'hF), rd, er);
        check("pre_reset_irqb", {31'h0, irq_b_o}, 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_irq_a", {31'h0, irq_a_o}, 32'h0);
        check("rst_irq_b", {31'h0, irq_b_o}, 32'h0);
        repeat (2) @(posedge clk);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        acc(1, mkreq(1, 0, 12'h008, 0, 4'hF), rd, er);
        check("post_reset_status_b", rd, 32'h5);
        acc(1, mkreq(1, 0, 12'h00C, 0, 4'hF), rd, er);
        check("post_reset_en_b", rd, 32'h0);
        check("post_reset_irq_a", {31'h0, irq_a_o}, 32'h0);
        check("post_reset_irq_b", {31'h0, irq_b_o}, 32'h0);

        for (int i = 0; i < 600; i++) cycle(randReq(), randReq(), rdA, rdB, erA, erB);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/carfield_mbox_unit.md
CARFIELD_MBOX_UNIT -- requirements
Module: carfield_mbox_unit

Interface
REQ-001 SHALL have parameter Depth, default 4, meaning FIFO entries per direction (power of two, 2..16).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide two register ports, side A (host) and side B (security island), each with these signals (x = a|b):
- reg_x_valid_i  input  1  request valid.
- reg_x_write_i  input  1  1 = write, 0 = read.
- reg_x_addr_i  input  12  byte offset within the 4 KiB window.
- reg_x_wdata_i  input  32  write data.
- reg_x_wstrb_i  input  4  byte strobes.
- reg_x_ready_o  output  1  response ready.
- reg_x_rdata_o  output  32  read data.
- reg_x_error_o  output  1  access error.
REQ-005 SHALL have port irq_a_o  output  1  interrupt to side A.
REQ-006 SHALL have port irq_b_o  output  1  interrupt to side B.

Function
REQ-007 SHALL contain FIFO AB (A writes, B reads) and FIFO BA (B writes, A reads), each Depth x 32 bit, with independent read/write pointers and a count of $clog2(Depth)+1 bits; pointers wrap modulo Depth.
REQ-008 SHALL assert reg_x_ready_o combinationally in the same cycle as reg_x_valid_i; rdata and error are valid in that cycle, with no wait states.
REQ-009 SHALL implement the same per-side map:
- 0x00 TXDATA (W): push to own TX FIFO.
- 0x04 RXDATA (R): pop from own RX FIFO.
- 0x08 STATUS (R): bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, [15:8] rx count.
- 0x0C IRQ_EN (RW): bit0 rx enable, bit1 overflow enable.
- 0x10 IRQ_STAT (R, W1C): bit0 rx_pending, bit1 tx_overflow.
REQ-010 SHALL apply TXDATA writes only when wstrb = 4'hF; a partial strobe raises error and leaves the FIFO unchanged.
REQ-011 SHALL, on a TXDATA write to a full TX FIFO, drop the data and raise error; fullness is judged on the pre-cycle count, even if the other side pops in the same cycle.
REQ-012 SHALL, on an RXDATA read of an empty FIFO, return 0 with error and leave the pointers unchanged.
REQ-013 SHALL return 0 with error for unmapped offsets, reads of TXDATA, writes to RXDATA and writes to STATUS.
REQ-014 SHALL handle a simultaneous push and pop on one FIFO by applying both, leaving the count unchanged; pop on empty errors while the concurrent push succeeds.
REQ-015 SHALL set the receiving side's rx_pending on the clock edge that completes a successful push; rx_pending stays set until cleared by W1C.
REQ-016 SHALL give set priority over clear when a W1C and a set event occur in the same cycle.
REQ-017 SHALL register irq_x_o = |(IRQ_EN & IRQ_STAT), so it asserts one cycle after the triggering edge.
REQ-018 SHALL ignore requests with valid low, with no state change.

Reset
REQ-019 SHALL, while rst_ni is low, clear both FIFO pointers and counts, IRQ_EN and IRQ_STAT, and drive irq_a_o and irq_b_o low.
REQ-020 SHALL discard all FIFO contents on reset mid-operation; after deassertion STATUS reads 0x0000_0005.
REQ-021 SHALL leave FIFO storage data unreset, with no functional effect.

Configuration
REQ-022 SHALL, with CARFIELD_MBOX_OVF_IRQ_EN defined, implement the tx_overflow sticky bit (set on a REQ-011 drop) and IRQ_EN bit1.
REQ-023 SHALL, without CARFIELD_MBOX_OVF_IRQ_EN, tie IRQ_STAT bit1 and IRQ_EN bit1 to 0 (writes ignored); a full-FIFO drop still signals error.

Verification
REQ-024 SHALL cover: A writes 0xDEAD_BEEF to 0x00, then B reads 0x04 -> 0xDEAD_BEEF, no error; B STATUS bit0 = 1 afterwards.
REQ-025 SHALL cover: B IRQ_EN = 1, A pushes one word -> irq_b_o high one cycle after the push edge; B writes 0x1 to 0x10 with the FIFO drained -> irq_b_o low next cycle.
REQ-026 SHALL cover: A pushes Depth+1 words (Depth = 4) -> fifth write error = 1; with the macro, A IRQ_STAT = 0x2; B then reads the 4 words in order.
REQ-027 SHALL cover: A reads 0x04 with BA empty -> rdata 0, error 1, STATUS unchanged.
REQ-028 SHALL cover: AB full, A push and B pop in the same cycle -> push error, pop returns the oldest word, count = 3.
REQ-029 SHALL cover: reset asserted with 2 words in AB -> after release B STATUS = 0x0000_0005, irq_a_o = irq_b_o = 0.
